// File: rtl/dual_queue_scheduler_if.sv
// Signal bundle between the dual-queue scheduler and its FIFOs/service counters.
// The scheduler takes the master side; the FIFO/counter environment takes the slave side.
interface dual_queue_scheduler_if #(
    parameter int NUM_W  = 4,
    parameter int TIME_W = 4
);
    logic              vip_empty;
    logic [NUM_W-1:0]  vip_qn;
    logic [TIME_W-1:0] vip_qt;
    logic              nrm_empty;
    logic [NUM_W-1:0]  nrm_qn;
    logic [TIME_W-1:0] nrm_qt;
    logic [2:0]        busy_in;

    logic              vip_re;
    logic              nrm_re;
    logic              ld1_out;
    logic              ld2_out;
    logic              ld3_out;
    logic [NUM_W-1:0]  dn1_out;
    logic [NUM_W-1:0]  dn2_out;
    logic [NUM_W-1:0]  dn3_out;
    logic [TIME_W-1:0] dt1_out;
    logic [TIME_W-1:0] dt2_out;
    logic [TIME_W-1:0] dt3_out;
    logic              src_out;
    logic              drop_out;
    logic [7:0]        disp_cnt;
    logic [1:0]        state_dbg;

    modport master (
        input  vip_empty, vip_qn, vip_qt, nrm_empty, nrm_qn, nrm_qt, busy_in,
        output vip_re, nrm_re, ld1_out, ld2_out, ld3_out,
               dn1_out, dn2_out, dn3_out, dt1_out, dt2_out, dt3_out,
               src_out, drop_out, disp_cnt, state_dbg
    );

    modport slave (
        output vip_empty, vip_qn, vip_qt, nrm_empty, nrm_qn, nrm_qt, busy_in,
        input  vip_re, nrm_re, ld1_out, ld2_out, ld3_out,
               dn1_out, dn2_out, dn3_out, dt1_out, dt2_out, dt3_out,
               src_out, drop_out, disp_cnt, state_dbg
    );
endinterface

// File: rtl/dual_queue_scheduler.sv
// Picks VIP or normal queue (VIP priority bounded by a starvation limit) and a free
// counter (round-robin), then pops the FIFO and loads the counter: one dispatch per 3 cycles.
module dual_queue_scheduler #(
    parameter int NUM_W      = 4,
    parameter int TIME_W     = 4,
    parameter int STARVE_LIM = 3,
    parameter int STARVE_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    dual_queue_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    state_t state;
    state_t state_nxt;

    logic [1:0]          rr_ptr;
    logic [STARVE_W-1:0] starve_cnt;
    logic                lat_src;
    logic                lat_drop;
    logic [1:0]          lat_idx;
    logic [NUM_W-1:0]    dn1_q, dn2_q, dn3_q;
    logic [TIME_W-1:0]   dt1_q, dt2_q, dt3_q;
    logic [7:0]          disp_q;

    logic                pick_vip;
    logic                has_src;
    logic [NUM_W-1:0]    head_qn;
    logic [TIME_W-1:0]   head_qt;
    logic                is_drop;
    logic                free_found;
    logic [1:0]          free_idx;
    logic                dispatch;

    // Counter indices live in 0..2; sums up to 4 fold back into that range.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        case (v)
            3'd3:    return 2'd0;
            3'd4:    return 2'd1;
            default: return v[1:0];
        endcase
    endfunction

    // Dispatch decision, only acted on while in S_IDLE.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        pick_vip   = 1'b0;
        has_src    = 1'b0;
        head_qn    = bus.nrm_qn;
        head_qt    = bus.nrm_qt;
        is_drop    = 1'b0;
        free_found = 1'b0;
        free_idx   = rr_ptr;
        dispatch   = 1'b0;

        pick_vip = !bus.vip_empty && (bus.nrm_empty || (starve_cnt < STARVE_MAX));
        has_src  = pick_vip || !bus.nrm_empty;
        if (pick_vip) begin
            head_qn = bus.vip_qn;
            head_qt = bus.vip_qt;
        end
        is_drop = has_src && (head_qt == '0);

        // Walk offsets high to low so the nearest free counter to rr_ptr wins.
        for (int off = 2; off >= 0; off--) begin
            if (!bus.busy_in[wrap3(3'(rr_ptr) + 3'(off))]) begin
                free_found = 1'b1;
                free_idx   = wrap3(3'(rr_ptr) + 3'(off));
            end
        end

        dispatch = has_src && (is_drop || free_found);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to S_IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = dispatch ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Latched dispatch, starvation tracking, counter payloads and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 2'd0;
            starve_cnt <= '0;
            lat_src    <= 1'b0;
            lat_drop   <= 1'b0;
            lat_idx    <= 2'd0;
            dn1_q      <= '0;
            dn2_q      <= '0;
            dn3_q      <= '0;
            dt1_q      <= '0;
            dt2_q      <= '0;
            dt3_q      <= '0;
            disp_q     <= 8'd0;
        end else begin
            if (state == S_IDLE && dispatch) begin
                lat_src  <= pick_vip;
                lat_drop <= is_drop;
                lat_idx  <= free_idx;

                if (pick_vip && !bus.nrm_empty) begin
                    if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    starve_cnt <= '0;
                end

                // Payload is placed a cycle early so it is stable while ld_k is high.
                if (!is_drop) begin
                    case (free_idx)
                        2'd0: begin dn1_q <= head_qn; dt1_q <= head_qt; end
                        2'd1: begin dn2_q <= head_qn; dt2_q <= head_qt; end
                        default: begin dn3_q <= head_qn; dt3_q <= head_qt; end
                    endcase
                end
            end

            if (state == S_ISSUE && !lat_drop) begin
                rr_ptr <= wrap3(3'(lat_idx) + 3'd1);
                disp_q <= disp_q + 8'd1;
            end
        end
    end

    // Output decode: strobes exist only in S_ISSUE.
    always_comb begin
        bus.vip_re   = (state == S_ISSUE) &&  lat_src;
        bus.nrm_re   = (state == S_ISSUE) && !lat_src;
        bus.ld1_out  = (state == S_ISSUE) && !lat_drop && (lat_idx == 2'd0);
        bus.ld2_out  = (state == S_ISSUE) && !lat_drop && (lat_idx == 2'd1);
        bus.ld3_out  = (state == S_ISSUE) && !lat_drop && (lat_idx == 2'd2);
        bus.src_out  = (state == S_ISSUE) &&  lat_src;
        bus.drop_out = (state == S_ISSUE) &&  lat_drop;
        bus.dn1_out  = dn1_q;
        bus.dn2_out  = dn2_q;
        bus.dn3_out  = dn3_q;
        bus.dt1_out  = dt1_q;
        bus.dt2_out  = dt2_q;
        bus.dt3_out  = dt3_q;
        bus.disp_cnt = disp_q;
        bus.state_dbg = state;
    end
endmodule

// File: tb/tb_dual_queue_scheduler.sv
// Directed bench for dual_queue_scheduler: hand-computed expectations for dispatch,
// round-robin, VIP starvation bound, drops, reset during issue and disp_cnt wrap.
module tb_dual_queue_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc;
    logic ld_seen;

    always #5 clk = ~clk;

    dual_queue_scheduler_if #(.NUM_W(4), .TIME_W(4)) bus ();

    dual_queue_scheduler #(
        .NUM_W(4), .TIME_W(4), .STARVE_LIM(3), .STARVE_W(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic set_vip(input logic empty, input logic [3:0] qn, input logic [3:0] qt);
        bus.vip_empty = empty;
        bus.vip_qn    = qn;
        bus.vip_qt    = qt;
    endtask

    task automatic set_nrm(input logic empty, input logic [3:0] qn, input logic [3:0] qt);
        bus.nrm_empty = empty;
        bus.nrm_qn    = qn;
        bus.nrm_qt    = qt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance negedge by negedge until S_ISSUE, bounded; returns cycles taken.
    task automatic wait_issue(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.state_dbg != 2'd1 && n < 12);
        check(tag, 32'(bus.state_dbg), 32'd1);
    endtask

    function automatic logic [2:0] lds();
        return {bus.ld3_out, bus.ld2_out, bus.ld1_out};
    endfunction

    initial begin
        set_vip(1'b1, 4'd0, 4'd0);
        set_nrm(1'b1, 4'd0, 4'd0);
        bus.busy_in = 3'b000;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        check("rst_strobes", 32'({bus.vip_re, bus.nrm_re, lds(), bus.src_out, bus.drop_out}), 32'd0);
        check("rst_disp", 32'(bus.disp_cnt), 32'd0);
        check("rst_dn1", 32'(bus.dn1_out), 32'd0);
        check("rst_dt3", 32'(bus.dt3_out), 32'd0);

        // Single normal customer qn=5 qt=3
        set_nrm(1'b0, 4'd5, 4'd3);
        rst = 1'b0;
        wait_issue("t1_issue", cyc);
        check("t1_latency", 32'(cyc), 32'd1);
        check("t1_nrm_re", 32'(bus.nrm_re), 32'd1);
        check("t1_vip_re", 32'(bus.vip_re), 32'd0);
        check("t1_ld", 32'(lds()), 32'b001);
        check("t1_dn1", 32'(bus.dn1_out), 32'd5);
        check("t1_dt1", 32'(bus.dt1_out), 32'd3);
        check("t1_src", 32'(bus.src_out), 32'd0);
        check("t1_drop", 32'(bus.drop_out), 32'd0);
        set_nrm(1'b0, 4'd6, 4'd2);
        bus.busy_in = 3'b001;
        @(negedge clk);
        check("t1_settle", 32'(bus.state_dbg), 32'd2);
        check("t1_settle_strb", 32'({bus.nrm_re, lds()}), 32'd0);
        check("t1_disp", 32'(bus.disp_cnt), 32'd1);
        // rr_ptr is now 1: with all counters free the next load goes to c2
        bus.busy_in = 3'b000;
        wait_issue("t1_rr_issue", cyc);
        check("t1_rr_ld", 32'(lds()), 32'b010);
        check("t1_rr_dn2", 32'(bus.dn2_out), 32'd6);
        set_nrm(1'b1, 4'd0, 4'd0);

        // Three normal customers go to c1,c2,c3 then a fourth waits
        do_reset();
        set_nrm(1'b0, 4'd1, 4'd4);
        wait_issue("t2_i1", cyc);
        check("t2_ld1", 32'(lds()), 32'b001);
        check("t2_dn1", 32'(bus.dn1_out), 32'd1);
        set_nrm(1'b0, 4'd2, 4'd5);
        bus.busy_in = 3'b001;
        wait_issue("t2_i2", cyc);
        check("t2_gap2", 32'(cyc), 32'd3);
        check("t2_ld2", 32'(lds()), 32'b010);
        check("t2_dn2", 32'(bus.dn2_out), 32'd2);
        check("t2_dt2", 32'(bus.dt2_out), 32'd5);
        set_nrm(1'b0, 4'd3, 4'd6);
        bus.busy_in = 3'b011;
        wait_issue("t2_i3", cyc);
        check("t2_gap3", 32'(cyc), 32'd3);
        check("t2_ld3", 32'(lds()), 32'b100);
        check("t2_dn3", 32'(bus.dn3_out), 32'd3);
        check("t2_dt3", 32'(bus.dt3_out), 32'd6);
        set_nrm(1'b0, 4'd4, 4'd7);
        bus.busy_in = 3'b111;
        ld_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            ld_seen = ld_seen | (|lds()) | bus.nrm_re;
        end
        check("t2_wait_strb", 32'(ld_seen), 32'd0);
        check("t2_wait_state", 32'(bus.state_dbg), 32'd0);
        check("t2_wait_disp", 32'(bus.disp_cnt), 32'd3);
        check("t2_dn1_hold", 32'(bus.dn1_out), 32'd1);
        // c2 and c3 free; search from rr_ptr=0 finds c2 first
        bus.busy_in = 3'b001;
        wait_issue("t2_i4", cyc);
        check("t2_ld4", 32'(lds()), 32'b010);
        check("t2_dn2_4", 32'(bus.dn2_out), 32'd4);
        check("t2_dt2_4", 32'(bus.dt2_out), 32'd7);
        set_nrm(1'b1, 4'd0, 4'd0);
        @(negedge clk);
        check("t2_disp4", 32'(bus.disp_cnt), 32'd4);

        // VIP priority with starvation limit 3
        bus.busy_in = 3'b000;
        do_reset();
        set_vip(1'b0, 4'd9, 4'd2);
        set_nrm(1'b0, 4'd6, 4'd3);
        for (int g = 0; g < 8; g++) begin
            logic [7:0] pat;
            pat = 8'b0111_0111;
            wait_issue("t3_issue", cyc);
            check($sformatf("t3_src%0d", g), 32'(bus.src_out), 32'(pat[g]));
            check($sformatf("t3_vre%0d", g), 32'(bus.vip_re), 32'(pat[g]));
            check($sformatf("t3_nre%0d", g), 32'(bus.nrm_re), 32'(!pat[g]));
        end
        set_vip(1'b1, 4'd0, 4'd0);
        set_nrm(1'b1, 4'd0, 4'd0);

        // Zero-time normal head with all counters busy drops
        do_reset();
        bus.busy_in = 3'b111;
        set_nrm(1'b0, 4'd7, 4'd0);
        wait_issue("t4_issue", cyc);
        check("t4_nrm_re", 32'(bus.nrm_re), 32'd1);
        check("t4_drop", 32'(bus.drop_out), 32'd1);
        check("t4_ld", 32'(lds()), 32'd0);
        set_nrm(1'b1, 4'd0, 4'd0);
        @(negedge clk);
        check("t4_disp", 32'(bus.disp_cnt), 32'd0);
        check("t4_drop_off", 32'(bus.drop_out), 32'd0);
        // rr_ptr unchanged by the drop: next load goes to c1
        bus.busy_in = 3'b000;
        set_nrm(1'b0, 4'd3, 4'd5);
        wait_issue("t4_after", cyc);
        check("t4_after_ld", 32'(lds()), 32'b001);
        check("t4_after_dn1", 32'(bus.dn1_out), 32'd3);

        // Reset asserted during S_ISSUE
        do_reset();
        set_nrm(1'b0, 4'd8, 4'd2);
        wait_issue("t5_issue", cyc);
        check("t5_pulse", 32'(lds()), 32'b001);
        rst = 1'b1;
        @(negedge clk);
        check("t5_state", 32'(bus.state_dbg), 32'd0);
        check("t5_strobes", 32'({bus.vip_re, bus.nrm_re, lds(), bus.drop_out}), 32'd0);
        check("t5_disp", 32'(bus.disp_cnt), 32'd0);
        check("t5_dn1", 32'(bus.dn1_out), 32'd0);
        rst = 1'b0;
        wait_issue("t5_redisp", cyc);
        check("t5_re_ld", 32'(lds()), 32'b001);
        check("t5_re_dn1", 32'(bus.dn1_out), 32'd8);
        set_nrm(1'b1, 4'd0, 4'd0);
        @(negedge clk);
        check("t5_re_disp", 32'(bus.disp_cnt), 32'd1);

        // 256 loads wrap disp_cnt; busy glitch in S_SETTLE is ignored
        do_reset();
        set_nrm(1'b0, 4'd1, 4'd1);
        for (int i = 0; i < 255; i++) wait_issue("t6_issue", cyc);
        @(negedge clk);
        check("t6_disp255", 32'(bus.disp_cnt), 32'd255);
        wait_issue("t6_last", cyc);
        bus.busy_in = 3'b111;
        @(negedge clk);
        check("t6_settle", 32'(bus.state_dbg), 32'd2);
        check("t6_wrap", 32'(bus.disp_cnt), 32'd0);
        bus.busy_in = 3'b000;
        @(negedge clk);
        bus.busy_in = 3'b111;
        ld_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ld_seen = ld_seen | (|lds()) | bus.nrm_re;
        end
        check("t6_no_extra", 32'(ld_seen), 32'd0);
        check("t6_disp_hold", 32'(bus.disp_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
